hnoc_link_arbiter: RTL and testbench

HNOC_LINK_ARBITER -- requirements
Module: hnoc_link_arbiter

---
 rtl/hnoc_link_arbiter.sv | 112 +++++++++++
 tb/tb_hnoc_link_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hnoc_link_arbiter.sv
// rtl/hnoc_link_arbiter.sv - 4-requester burst round-robin arbiter onto a single registered link.
// Sticks with one requester for up to BurstLen flits, then rotates priority.
module hnoc_link_arbiter #(
    parameter int DataWidth = 36,
    parameter int BurstLen  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [4*DataWidth-1:0] i_req_data,
    input  logic [3:0]             i_req_valid,
    output logic [3:0]             o_req_ready,
    output logic [DataWidth-1:0]   o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [1:0]             o_grant_id,
    output logic                   o_busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    localparam logic [3:0] BurstMax = 4'(BurstLen - 1);

    state_e               state_q, state_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [1:0]           grant_id_q, grant_id_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [3:0]           burst_cnt_q, burst_cnt_d;
    logic                 last_vld_q, last_vld_d;
    logic [1:0]           last_grant_q, last_grant_d;

    logic       load_en;
    logic       burst_cont;
    logic       rr_found;
    logic [1:0] rr_sel;
    logic [1:0] sel;
    logic       accept;

    // Descending search so the requester closest to ptr wins.
    always_comb begin
        load_en    = (state_q == ST_IDLE) || i_ready;
        burst_cont = last_vld_q && i_req_valid[last_grant_q] && (burst_cnt_q < BurstMax);
        rr_found   = 1'b0;
        rr_sel     = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (i_req_valid[ptr_q + 2'(i)]) begin
                rr_found = 1'b1;
                rr_sel   = ptr_q + 2'(i);
            end
        end
        sel    = burst_cont ? last_grant_q : rr_sel;
        accept = load_en && (burst_cont || rr_found) && i_reset_n;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            data_q       <= '0;
            grant_id_q   <= '0;
            ptr_q        <= '0;
            burst_cnt_q  <= '0;
            last_vld_q   <= 1'b0;
            last_grant_q <= '0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            grant_id_q   <= grant_id_d;
            ptr_q        <= ptr_d;
            burst_cnt_q  <= burst_cnt_d;
            last_vld_q   <= last_vld_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_FULL;
            ST_FULL: if (i_ready) state_d = accept ? ST_FULL : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbitration state only moves on an accept, so backpressure freezes it.
    always_comb begin
        data_d       = data_q;
        grant_id_d   = grant_id_q;
        ptr_d        = ptr_q;
        burst_cnt_d  = burst_cnt_q;
        last_vld_d   = last_vld_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            data_d       = i_req_data[int'(sel)*DataWidth +: DataWidth];
            grant_id_d   = sel;
            ptr_d        = sel + 2'd1;
            burst_cnt_d  = burst_cont ? burst_cnt_q + 4'd1 : 4'd0;
            last_vld_d   = 1'b1;
            last_grant_d = sel;
        end
    end

    always_comb begin
        o_valid     = (state_q == ST_FULL);
        o_data      = data_q;
        o_grant_id  = grant_id_q;
        o_req_ready = accept ? (4'b0001 << sel) : 4'b0000;
        o_busy      = (state_q == ST_FULL) || (|i_req_valid);
    end

endmodule

// File: tb/tb_hnoc_link_arbiter.sv
// tb/tb_hnoc_link_arbiter.sv - self-checking bench for hnoc_link_arbiter against a queue-free arbitration model.
module tb_hnoc_link_arbiter;

    localparam int DW = 36;
    localparam int BL = 4;

    logic            i_clk = 1'b0;
    logic            i_reset_n = 1'b1;
    logic [4*DW-1:0] i_req_data = '0;
    logic [3:0]      i_req_valid = '0;
    logic            i_ready = 1'b0;

    logic [3:0]    o_req_ready;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic [1:0]    o_grant_id;
    logic          o_busy;

    logic [3:0]    rr_req_ready;
    logic [DW-1:0] rr_data;
    logic          rr_valid;
    logic [1:0]    rr_grant_id;
    logic          rr_busy;

    hnoc_link_arbiter #(.DataWidth(DW), .BurstLen(BL)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_req_data(i_req_data),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .o_data(o_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_grant_id(o_grant_id), .o_busy(o_busy)
    );

    hnoc_link_arbiter #(.DataWidth(DW), .BurstLen(1)) dut_rr (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_req_data(i_req_data),
        .i_req_valid(i_req_valid), .o_req_ready(rr_req_ready), .o_data(rr_data),
        .o_valid(rr_valid), .i_ready(i_ready), .o_grant_id(rr_grant_id), .o_busy(rr_busy)
    );

    always #5 i_clk = ~i_clk;

    int tests_run = 0;
    int tests_failed = 0;

    int            m_ptr;
    int            m_last;
    int            m_run;
    logic          exp_ov;
    logic [DW-1:0] exp_od;
    logic [1:0]    exp_og;

    task automatic model_reset();
        m_ptr  = 0;
        m_last = -1;
        m_run  = 0;
        exp_ov = 1'b0;
    endtask

    function automatic int model_sel(input logic [3:0] v);
        if (m_last >= 0 && v[m_last] && m_run < BL - 1) return m_last;
        for (int i = 0; i < 4; i++)
            if (v[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
        return -1;
    endfunction

    task automatic cycle(input logic [3:0] v, input logic rdy, input bit rand_data);
        int         s;
        bit         cont;
        bit         le;
        logic [3:0] er;
        logic [63:0] r64;
        if (rand_data) begin
            for (int k = 0; k < 4; k++) begin
                r64 = {$urandom, $urandom};
                i_req_data[k*DW +: DW] = r64[DW-1:0];
            end
        end
        i_req_valid = v;
        i_ready     = rdy;
        #1;
        s    = model_sel(v);
        cont = (m_last >= 0 && v[m_last] && m_run < BL - 1);
        le   = !exp_ov || rdy;
        er   = (le && s >= 0) ? (4'b0001 << s) : 4'b0000;
        tests_run++;
        if (o_req_ready !== er) begin
            tests_failed++;
            $display("FAIL req_ready: got %b expected %b (valid %b ready %b)", o_req_ready, er, v, rdy);
        end
        tests_run++;
        if (o_busy !== (exp_ov || (|v))) begin
            tests_failed++;
            $display("FAIL busy: got %b expected %b", o_busy, exp_ov || (|v));
        end
        @(posedge i_clk);
        if (le && s >= 0) begin
            exp_od = i_req_data[s*DW +: DW];
            exp_og = 2'(s);
            exp_ov = 1'b1;
            m_run  = (cont && s == m_last) ? m_run + 1 : 0;
            m_last = s;
            m_ptr  = (s + 1) % 4;
        end else if (le) begin
            exp_ov = 1'b0;
        end
        #1;
        tests_run++;
        if (o_valid !== exp_ov) begin
            tests_failed++;
            $display("FAIL valid: got %b expected %b", o_valid, exp_ov);
        end
        if (exp_ov) begin
            tests_run++;
            if (o_data !== exp_od) begin
                tests_failed++;
                $display("FAIL data: got %h expected %h", o_data, exp_od);
            end
            tests_run++;
            if (o_grant_id !== exp_og) begin
                tests_failed++;
                $display("FAIL grant_id: got %0d expected %0d", o_grant_id, exp_og);
            end
        end
    endtask

    task automatic apply_reset();
        i_reset_n   = 1'b0;
        i_req_valid = 4'hf;
        i_ready     = 1'b1;
        #1;
        tests_run++;
        if (o_valid !== 1'b0 || rr_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid: got %b/%b expected 0/0", o_valid, rr_valid);
        end
        tests_run++;
        if (o_data !== '0 || o_grant_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h/%0d expected 0/0", o_data, o_grant_id);
        end
        tests_run++;
        if (o_req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b expected 0000", o_req_ready);
        end
        tests_run++;
        if (o_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_busy_hi: got %b expected 1", o_busy);
        end
        i_req_valid = 4'h0;
        #1;
        tests_run++;
        if (o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy_lo: got %b expected 0", o_busy);
        end
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        i_req_data = '0;
        i_req_data[1*DW +: DW] = 36'h5_0000_00AA;
        cycle(4'b0010, 1'b1, 1'b0);
        tests_run++;
        if (o_valid !== 1'b1 || o_data !== 36'h5_0000_00AA || o_grant_id !== 2'd1) begin
            tests_failed++;
            $display("FAIL single: got v=%b d=%h g=%0d expected v=1 d=5000000aa g=1", o_valid, o_data, o_grant_id);
        end
        cycle(4'b0000, 1'b1, 1'b0);
    endtask

    task automatic test_burst_sequence();
        int seq[17];
        seq = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
        apply_reset();
        for (int n = 0; n < 17; n++) begin
            cycle(4'hf, 1'b1, 1'b1);
            tests_run++;
            if (o_valid !== 1'b1 || o_grant_id !== 2'(seq[n])) begin
                tests_failed++;
                $display("FAIL burst_seq[%0d]: got v=%b g=%0d expected v=1 g=%0d", n, o_valid, o_grant_id, seq[n]);
            end
        end
    endtask

    task automatic test_round_robin();
        int seq[6];
        seq = '{0,1,2,3,0,1};
        apply_reset();
        for (int n = 0; n < 6; n++) begin
            cycle(4'hf, 1'b1, 1'b1);
            tests_run++;
            if (rr_valid !== 1'b1 || rr_grant_id !== 2'(seq[n])) begin
                tests_failed++;
                $display("FAIL rr_seq[%0d]: got v=%b g=%0d expected v=1 g=%0d", n, rr_valid, rr_grant_id, seq[n]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held_d;
        logic [1:0]    held_g;
        apply_reset();
        cycle(4'hf, 1'b1, 1'b1);
        cycle(4'hf, 1'b1, 1'b1);
        held_d = o_data;
        held_g = o_grant_id;
        repeat (5) cycle(4'hf, 1'b0, 1'b1);
        tests_run++;
        if (o_data !== held_d || o_grant_id !== held_g || o_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_hold: got %h/%0d expected %h/%0d", o_data, o_grant_id, held_d, held_g);
        end
        cycle(4'hf, 1'b1, 1'b1);
        tests_run++;
        if (o_grant_id !== 2'd0 || o_data === held_d) begin
            tests_failed++;
            $display("FAIL backpressure_reload: got g=%0d d=%h expected g=0 with new data", o_grant_id, o_data);
        end
    endtask

    task automatic test_burst_break();
        apply_reset();
        cycle(4'b0100, 1'b1, 1'b1);
        cycle(4'b0100, 1'b1, 1'b1);
        cycle(4'b0001, 1'b1, 1'b1);
        tests_run++;
        if (o_grant_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL burst_break: got %0d expected 0", o_grant_id);
        end
        repeat (3) cycle(4'b0001, 1'b1, 1'b1);
        cycle(4'b0011, 1'b1, 1'b1);
        tests_run++;
        if (o_grant_id !== 2'd1) begin
            tests_failed++;
            $display("FAIL burst_break_rotate: got %0d expected 1", o_grant_id);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        repeat (3) cycle(4'hf, 1'b1, 1'b1);
        #2;
        i_reset_n = 1'b0;
        #1;
        tests_run++;
        if (o_valid !== 1'b0 || o_data !== '0 || o_req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_mid: got v=%b d=%h r=%b expected 0/0/0000", o_valid, o_data, o_req_ready);
        end
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        model_reset();
        cycle(4'hf, 1'b1, 1'b1);
        tests_run++;
        if (o_grant_id !== 2'd0 || o_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_first: got v=%b g=%0d expected v=1 g=0", o_valid, o_grant_id);
        end
    endtask

    task automatic test_random();
        logic [3:0] v;
        logic       r;
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            v = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 3) != 0);
            cycle(v, r, 1'b1);
        end
    endtask

    initial begin
        model_reset();
        @(posedge i_clk);
        #1;
        test_reset();
        test_single();
        test_burst_sequence();
        test_round_robin();
        test_backpressure();
        test_burst_break();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
